// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared encodings for the multicycle control unit
// Purpose: state enum, opcode/funct constants, aluop/alucont, pcsource and
// alusrcb encodings used by multicycle_ctrl and mc_alu_dec.
// Optional feature macro: MULTICYCLE_CTRL_JAL_EN (adds the S_JALEX state).
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_LBRD,
        S_LBWR,
        S_SBWR,
        S_RTYPEEX,
        S_RTYPEWR,
        S_ADDIEX,
        S_ADDIWR,
        S_BEQEX,
        S_BNEEX,
        S_JEX
`ifdef MULTICYCLE_CTRL_JAL_EN
        , S_JALEX
`endif
    } state_t;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b001000;
    localparam logic [5:0] OP_JAL   = 6'b000110;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_INC  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - memory request/ready bundle of the control unit
// Signals: memread, memwrite, iord (controller to memory), mem_ready (memory
// to controller). master = control unit side, slave = memory side.
interface multicycle_ctrl_if;
    logic memread;
    logic memwrite;
    logic iord;
    logic mem_ready;

    modport master (output memread, output memwrite, output iord, input mem_ready);
    modport slave  (input memread, input memwrite, input iord, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_alu_dec.sv
// rtl/multicycle_ctrl_alu_dec.sv - combinational ALU control decoder
// Ports: aluop (in, 2) operation class, funct (in, 6) R-type function field,
// alucont (out, 3) ALU operation select.
module mc_alu_dec
    import multicycle_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucont
);

    always_comb begin
        alucont = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucont = ALU_ADD;
            ALUOP_SUB: alucont = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucont = ALU_ADD;
                    FN_SUB:  alucont = ALU_SUB;
                    FN_AND:  alucont = ALU_AND;
                    FN_OR:   alucont = ALU_OR;
                    FN_SLT:  alucont = ALU_SLT;
                    default: alucont = ALU_ADD;
                endcase
            end
            default: alucont = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS control FSM with multi-beat fetch
// Ports: clk, reset (async, active-high); op, funct (IR fields);
// bus (multicycle_ctrl_if.master: memread, memwrite, iord, mem_ready);
// irwrite (one-hot IR lane enable), pcwrite, branch, branchne, pcsource,
// alusrca, alusrcb, regwrite, regdst, memtoreg, link, alucont, illegal_op.
// Optional feature macro: MULTICYCLE_CTRL_JAL_EN enables the JAL opcode.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter  int INSTR_W     = 32,
    parameter  int MEM_W       = 8,
    localparam int FETCH_BEATS = INSTR_W / MEM_W,
    localparam int BEAT_W      = (FETCH_BEATS > 1) ? $clog2(FETCH_BEATS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             op,
    input  logic [5:0]             funct,
    multicycle_ctrl_if.master      bus,
    output logic [FETCH_BEATS-1:0] irwrite,
    output logic                   pcwrite,
    output logic                   branch,
    output logic                   branchne,
    output logic [1:0]             pcsource,
    output logic                   alusrca,
    output logic [1:0]             alusrcb,
    output logic                   regwrite,
    output logic                   regdst,
    output logic                   memtoreg,
    output logic                   link,
    output logic [2:0]             alucont,
    output logic                   illegal_op
);

    localparam logic [BEAT_W-1:0]      LAST_BEAT = BEAT_W'(FETCH_BEATS - 1);
    localparam logic [FETCH_BEATS-1:0] LANE0     = FETCH_BEATS'(1);

    state_t            state, state_n;
    logic [BEAT_W-1:0] beat, beat_n;
    aluop_t            aluop;
    logic              memread, memwrite, iord;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            beat  <= '0;
        end else begin
            state <= state_n;
            beat  <= beat_n;
        end
    end

    always_comb begin
        state_n    = state;
        beat_n     = beat;
        aluop      = ALUOP_ADD;
        memread    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = '0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        branchne   = 1'b0;
        pcsource   = PCSRC_ALU;
        alusrca    = 1'b0;
        alusrcb    = SRCB_REG;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        link       = 1'b0;
        illegal_op = 1'b0;

        case (state)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = SRCB_INC;
                // Each accepted beat loads one IR lane and bumps the PC by one
                // memory word; a stalled beat writes nothing.
                if (bus.mem_ready) begin
                    irwrite = LANE0 << beat;
                    pcwrite = 1'b1;
                    if (beat == LAST_BEAT) begin
                        beat_n  = '0;
                        state_n = S_DECODE;
                    end else begin
                        beat_n = beat + 1'b1;
                    end
                end
            end
            S_DECODE: begin
                alusrcb = SRCB_BOFF;
                case (op)
                    OP_LB, OP_SB: state_n = S_MEMADR;
                    OP_RTYPE:     state_n = S_RTYPEEX;
                    OP_BEQ:       state_n = S_BEQEX;
                    OP_BNE:       state_n = S_BNEEX;
                    OP_ADDI:      state_n = S_ADDIEX;
                    OP_J:         state_n = S_JEX;
`ifdef MULTICYCLE_CTRL_JAL_EN
                    OP_JAL:       state_n = S_JALEX;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_n    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_n = (op == OP_SB) ? S_SBWR : S_LBRD;
            end
            S_LBRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (bus.mem_ready) state_n = S_LBWR;
            end
            S_LBWR: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                state_n  = S_FETCH;
            end
            S_SBWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                if (bus.mem_ready) state_n = S_FETCH;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_n = S_RTYPEWR;
            end
            S_RTYPEWR: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                state_n  = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_n = S_ADDIWR;
            end
            S_ADDIWR: begin
                regwrite = 1'b1;
                state_n  = S_FETCH;
            end
            S_BEQEX: begin
                alusrca  = 1'b1;
                aluop    = ALUOP_SUB;
                branch   = 1'b1;
                pcsource = PCSRC_ALUOUT;
                state_n  = S_FETCH;
            end
            S_BNEEX: begin
                alusrca  = 1'b1;
                aluop    = ALUOP_SUB;
                branchne = 1'b1;
                pcsource = PCSRC_ALUOUT;
                state_n  = S_FETCH;
            end
            S_JEX: begin
                pcwrite  = 1'b1;
                pcsource = PCSRC_JUMP;
                state_n  = S_FETCH;
            end
`ifdef MULTICYCLE_CTRL_JAL_EN
            S_JALEX: begin
                pcwrite  = 1'b1;
                pcsource = PCSRC_JUMP;
                link     = 1'b1;
                regwrite = 1'b1;
                state_n  = S_FETCH;
            end
`endif
            default: state_n = S_FETCH;
        endcase

        // The state register clears asynchronously, but mem_ready could still
        // raise a FETCH write combinationally; hold every enable low in reset.
        if (reset) begin
            irwrite  = '0;
            pcwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
            branch   = 1'b0;
            branchne = 1'b0;
            link     = 1'b0;
        end
    end

    assign bus.memread  = memread;
    assign bus.memwrite = memwrite;
    assign bus.iord     = iord;

    mc_alu_dec u_alu_dec (
        .aluop   (aluop),
        .funct   (funct),
        .alucont (alucont)
    );

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multicycle MIPS control unit for the team's CPU. It fetches one instruction over a configurable-width memory port in FETCH_BEATS beats, with a ready handshake that stalls any memory state. It decodes the extended opcode set (adds BNE and ADDI) and drives all datapath mux selects, write enables and the 3-bit ALU control. It sits between the instruction register and opcode field and the shared multicycle datapath.

## Interface
- INSTR_W, 32: instruction width in bits.
- MEM_W, 8: memory data width; legal values are 8, 16 and 32.
- FETCH_BEATS, INSTR_W/MEM_W: derived, not overridable.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- op  in  6  opcode field, IR[31:26].
- funct  in  6  function field, IR[5:0].
- mem_ready  in  1  memory completed the current beat or access this cycle.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- irwrite  out  FETCH_BEATS  one-hot IR lane write enable.
- pcwrite  out  1  unconditional PC write.
- branch  out  1  PC write if zero.
- branchne  out  1  PC write if not zero.
- pcsource  out  2  PC source: 00 ALU, 01 ALUOut, 10 jump target.
- alusrca  out  1  ALU A: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B: 00 = register B, 01 = MEM_W/8, 10 = signext imm, 11 = branch offset.
- regwrite  out  1  register file write.
- regdst  out  1  write-register select: 0 = rt, 1 = rd.
- memtoreg  out  1  write data: 0 = ALUOut, 1 = MDR.
- link  out  1  write PC to r31.
- alucont  out  3  ALU operation.
- illegal_op  out  1  one-cycle pulse on an undecodable opcode.

## Operation
- Opcodes: LB 100000, SB 101000, RTYPE 000000, BEQ 000010, BNE 000011, ADDI 000100, J 001000, JAL 000110 (macro only).
- Internal aluop: 00 add, 01 sub, 10 funct.
- funct to alucont mapping:
  - 100000 → 010 (add)
  - 100010 → 110 (sub)
  - 100100 → 000 (and)
  - 100101 → 001 (or)
  - 101010 → 111 (slt)
  - any other funct → 010.
- States and their asserted outputs (every unlisted output is 0):
  - FETCH: memread, alusrcb=01. Beat counter `beat` selects the irwrite lane.
    - On mem_ready: irwrite[beat]=1, pcwrite=1, beat increments.
    - Without mem_ready: irwrite=0 and pcwrite=0 (stall).
    - Leave FETCH when mem_ready arrives with beat==FETCH_BEATS-1; beat returns to 0.
  - DECODE: alusrcb=11, aluop=00. Next state by op; an unknown op goes to FETCH and pulses illegal_op.
  - MEMADR: alusrca=1, alusrcb=10. Next is LBRD for LB, SBWR for SB.
  - LBRD: memread, iord. Holds until mem_ready, then goes to LBWR.
  - LBWR: regwrite, memtoreg.
  - SBWR: memwrite, iord. Holds until mem_ready, then goes to FETCH.
  - RTYPEEX: alusrca=1, aluop=10. RTYPEWR: regwrite, regdst.
  - ADDIEX: alusrca=1, alusrcb=10. ADDIWR: regwrite.
  - BEQEX: alusrca=1, aluop=01, branch, pcsource=01.
  - BNEEX: same as BEQEX but drives branchne instead of branch.
  - JEX: pcwrite, pcsource=10.
  - JALEX: JEX outputs plus link and regwrite.
- Terminal states (LBWR, SBWR, RTYPEWR, ADDIWR, BEQEX, BNEEX, JEX, JALEX) all return to FETCH.
- memread and memwrite are never asserted in the same cycle.

## Timing
- All outputs are combinational from state, beat and mem_ready. illegal_op is also combinational and is high for exactly the one DECODE cycle.
- Cycle counts with mem_ready tied high and MEM_W=8:
  - LB 8
  - SB, RTYPE, ADDI 7
  - BEQ, BNE, J, JAL 6.
- Each fetch beat adds one cycle per cycle of mem_ready low. LBRD and SBWR extend the same way.
- Reset:
  - state=FETCH, beat=0.
  - While reset is high, every write enable is forced to 0: irwrite, pcwrite, regwrite, memwrite, branch, branchne, link.
  - memread=1 and alusrcb=01 still drive during reset.
- Reset asserted mid-instruction aborts it immediately. There is no partial commit after reset rises.
- A mem_ready pulse in a non-memory state is ignored.

## Configuration
- MULTICYCLE_CTRL_JAL_EN defined:
  - JAL decodes to JALEX.
  - link is driven as specified.
- MULTICYCLE_CTRL_JAL_EN undefined:
  - opcode 000110 is illegal and pulses illegal_op.
  - JALEX does not exist.
  - link is tied to 0; the port is still present.

## Structure
- Package multicycle_pkg holds:
  - the state enum
  - opcode constants
  - funct constants
  - aluop and alucont encodings
  - the pcsource and alusrcb encodings.
- One sub-module, mc_alu_dec: combinational (aluop, funct) → alucont.
- beat width is max(1, $clog2(FETCH_BEATS)).

## Test plan
- MEM_W=8, mem_ready=1, RTYPE add (funct 100000):
  - irwrite sequence 0001, 0010, 0100, 1000
  - alucont=010 in RTYPEEX
  - regwrite and regdst in cycle 7.
- MEM_W=32, LB with mem_ready low for 3 cycles in LBRD:
  - FETCH lasts 1 cycle with irwrite=1
  - LBRD lasts 4 cycles, iord held
  - regwrite and memtoreg exactly once.
- MEM_W=16, BNE then BEQ:
  - branchne only in BNEEX, branch only in BEQEX
  - alucont=110 in both
  - each instruction takes 4 cycles.
- op=111111:
  - illegal_op high for exactly 1 cycle
  - the next cycle is FETCH with beat=0
  - no write enables asserted during the instruction.
- reset pulsed during SBWR:
  - memwrite drops within the same cycle
  - after release, FETCH beat 0.
- JAL with the macro defined: link, regwrite and pcwrite in cycle 6. Without the macro: illegal_op pulses and link stays 0.
